// File: rtl/instr_fetch.sv
// Instruction fetch stage: issues 16-bit instruction-memory requests, presents fetched
// words to decode, and squashes in-flight fetches when execute redirects the PC.
module instr_fetch #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter logic [15:0] PC_INC   = 16'd2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_ack,
    input  logic [15:0] imem_rdata,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [15:0] if_instr,
    output logic [2:0]  if_opcode,
    output logic [15:0] if_pc,
    output logic [15:0] if_pc_plus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        DROP  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] tgt_q, tgt_d;
    logic        valid_q, valid_d;
    logic [15:0] instr_q, instr_d;
    logic [15:0] ipc_q, ipc_d;
    logic [15:0] plus_q, plus_d;
    logic [15:0] redir_pc;

    // Targets are halfword aligned; bit 0 of an incoming target is discarded.
    assign redir_pc = redirect_pc & 16'hFFFE;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        addr_d  = addr_q;
        tgt_d   = tgt_q;
        valid_d = valid_q;
        instr_d = instr_q;
        ipc_d   = ipc_q;
        plus_d  = plus_q;

        case (state_q)
            IDLE: begin
                valid_d = 1'b0;
                state_d = FETCH;
                if (redirect) begin
                    pc_d   = redir_pc;
                    addr_d = redir_pc;
                end else begin
                    addr_d = pc_q;
                end
            end

            FETCH: begin
                if (redirect) begin
                    if (imem_ack) begin
                        // Returned word belongs to the old path: drop it and re-issue at once.
                        pc_d   = redir_pc;
                        addr_d = redir_pc;
                    end else begin
                        tgt_d   = redir_pc;
                        state_d = DROP;
                    end
                end else if (imem_ack) begin
                    instr_d = imem_rdata;
                    ipc_d   = pc_q;
                    plus_d  = pc_q + PC_INC;
                    valid_d = 1'b1;
                    pc_d    = pc_q + PC_INC;
                    state_d = HOLD;
                end
            end

            HOLD: begin
                if (redirect) begin
                    pc_d    = redir_pc;
                    addr_d  = redir_pc;
                    valid_d = 1'b0;
                    state_d = FETCH;
                end else if (if_ready) begin
                    addr_d  = pc_q;
                    valid_d = 1'b0;
                    state_d = FETCH;
                end
            end

            DROP: begin
                // The stale request must still complete before the target can be fetched.
                if (redirect) begin
                    tgt_d = redir_pc;
                end else if (imem_ack) begin
                    pc_d    = tgt_q;
                    addr_d  = tgt_q;
                    state_d = FETCH;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            addr_q  <= 16'h0000;
            tgt_q   <= 16'h0000;
            valid_q <= 1'b0;
            instr_q <= 16'h0000;
            ipc_q   <= 16'h0000;
            plus_q  <= 16'h0000;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            addr_q  <= addr_d;
            tgt_q   <= tgt_d;
            valid_q <= valid_d;
            instr_q <= instr_d;
            ipc_q   <= ipc_d;
            plus_q  <= plus_d;
        end
    end

    assign imem_req   = (state_q == FETCH) || (state_q == DROP);
    assign imem_addr  = addr_q;
    assign if_valid   = valid_q;
    assign if_instr   = instr_q;
    assign if_opcode  = instr_q[15:13];
    assign if_pc      = ipc_q;
    assign if_pc_plus = plus_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: sequential fetch, decode stall, redirect cases,
// PC wrap and asynchronous reset during a squashed fetch.
module tb_instr_fetch;

    logic        clk;
    logic        reset;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack;
    logic [15:0] imem_rdata;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        if_valid;
    logic        if_ready;
    logic [15:0] if_instr;
    logic [2:0]  if_opcode;
    logic [15:0] if_pc;
    logic [15:0] if_pc_plus;

    int n_cmp = 0;
    int n_err = 0;

    instr_fetch dut (
        .clk         (clk),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .if_valid    (if_valid),
        .if_ready    (if_ready),
        .if_instr    (if_instr),
        .if_opcode   (if_opcode),
        .if_pc       (if_pc),
        .if_pc_plus  (if_pc_plus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset       = 1'b0;
        imem_ack    = 1'b0;
        imem_rdata  = 16'h0000;
        redirect    = 1'b0;
        redirect_pc = 16'h0000;
        if_ready    = 1'b0;
        step;
        step;

        check("rst_req",   32'(imem_req),   32'h0);
        check("rst_addr",  32'(imem_addr),  32'h0);
        check("rst_valid", 32'(if_valid),   32'h0);
        check("rst_instr", 32'(if_instr),   32'h0);
        check("rst_opc",   32'(if_opcode),  32'h0);
        check("rst_pc",    32'(if_pc),      32'h0);
        check("rst_plus",  32'(if_pc_plus), 32'h0);

        // Sequential fetch, memory and decode always ready
        imem_ack   = 1'b1;
        if_ready   = 1'b1;
        imem_rdata = 16'h2004;
        reset      = 1'b1;
        step;
        check("seq_req0",  32'(imem_req),  32'h1);
        check("seq_addr0", 32'(imem_addr), 32'h0000);
        check("seq_vld0",  32'(if_valid),  32'h0);
        step;
        check("seq_req_h",  32'(imem_req),   32'h0);
        check("seq_vld1",   32'(if_valid),   32'h1);
        check("seq_instr1", 32'(if_instr),   32'h2004);
        check("seq_opc1",   32'(if_opcode),  32'h1);
        check("seq_pc1",    32'(if_pc),      32'h0000);
        check("seq_plus1",  32'(if_pc_plus), 32'h0002);
        step;
        check("seq_addr2", 32'(imem_addr), 32'h0002);
        check("seq_vld2",  32'(if_valid),  32'h0);
        step;
        check("seq_pc2",   32'(if_pc),      32'h0002);
        check("seq_plus2", 32'(if_pc_plus), 32'h0004);
        step;
        check("seq_addr4", 32'(imem_addr), 32'h0004);
        step;
        check("seq_pc4",  32'(if_pc),    32'h0004);
        check("seq_vld4", 32'(if_valid), 32'h1);

        // Decode stall in HOLD for 5 cycles
        if_ready   = 1'b0;
        imem_rdata = 16'hA55A;
        for (int i = 0; i < 5; i++) begin
            step;
            check("stall_vld",   32'(if_valid), 32'h1);
            check("stall_pc",    32'(if_pc),    32'h0004);
            check("stall_instr", 32'(if_instr), 32'h2004);
            check("stall_req",   32'(imem_req), 32'h0);
        end
        if_ready = 1'b1;
        step;
        check("stall_rel_addr", 32'(imem_addr), 32'h0006);
        check("stall_rel_req",  32'(imem_req),  32'h1);
        check("stall_rel_vld",  32'(if_valid),  32'h0);

        // Delayed ack with redirect overtaking the outstanding request
        imem_ack = 1'b0;
        step;
        check("dly_addr1", 32'(imem_addr), 32'h0006);
        redirect    = 1'b1;
        redirect_pc = 16'h0041;
        step;
        redirect   = 1'b0;
        imem_rdata = 16'h1111;
        check("drop_req",  32'(imem_req),  32'h1);
        check("drop_addr", 32'(imem_addr), 32'h0006);
        check("drop_vld",  32'(if_valid),  32'h0);
        step;
        check("drop_addr2", 32'(imem_addr), 32'h0006);
        imem_ack = 1'b1;
        step;
        imem_ack = 1'b0;
        check("drop_tgt_addr", 32'(imem_addr), 32'h0040);
        check("drop_tgt_vld",  32'(if_valid),  32'h0);
        step;
        check("drop_no_vld", 32'(if_valid),  32'h0);
        check("drop_addr3",  32'(imem_addr), 32'h0040);

        // Redirect coinciding with ack
        imem_ack    = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 16'h0100;
        step;
        check("rack_addr", 32'(imem_addr), 32'h0100);
        check("rack_vld",  32'(if_valid),  32'h0);
        check("rack_req",  32'(imem_req),  32'h1);
        redirect   = 1'b0;
        imem_rdata = 16'h4321;
        if_ready   = 1'b0;
        step;
        check("rack_got_vld",  32'(if_valid),   32'h1);
        check("rack_got_pc",   32'(if_pc),      32'h0100);
        check("rack_got_opc",  32'(if_opcode),  32'h2);
        check("rack_got_plus", 32'(if_pc_plus), 32'h0102);

        // Redirect in HOLD together with if_ready, then PC wrap
        if_ready    = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 16'hFFFE;
        step;
        check("hredir_vld",  32'(if_valid),  32'h0);
        check("hredir_addr", 32'(imem_addr), 32'hFFFE);
        redirect   = 1'b0;
        if_ready   = 1'b0;
        imem_rdata = 16'hE000;
        step;
        check("wrap_pc",   32'(if_pc),      32'hFFFE);
        check("wrap_plus", 32'(if_pc_plus), 32'h0000);
        check("wrap_opc",  32'(if_opcode),  32'h7);
        if_ready = 1'b1;
        step;
        check("wrap_addr", 32'(imem_addr), 32'h0000);
        step;
        imem_ack = 1'b0;
        check("pre_drop_pc", 32'(if_pc), 32'h0000);
        step;
        check("pre_drop_addr", 32'(imem_addr), 32'h0002);
        redirect    = 1'b1;
        redirect_pc = 16'h0300;
        step;
        redirect = 1'b0;
        check("rd_drop_addr", 32'(imem_addr), 32'h0002);
        check("rd_drop_req",  32'(imem_req),  32'h1);

        // Asynchronous reset while in DROP
        #3;
        reset = 1'b0;
        #1;
        check("ar_req",   32'(imem_req),   32'h0);
        check("ar_addr",  32'(imem_addr),  32'h0);
        check("ar_vld",   32'(if_valid),   32'h0);
        check("ar_instr", 32'(if_instr),   32'h0);
        check("ar_pc",    32'(if_pc),      32'h0);
        check("ar_plus",  32'(if_pc_plus), 32'h0);
        imem_ack = 1'b1;
        step;
        reset = 1'b1;
        step;
        check("ar_rel_addr", 32'(imem_addr), 32'h0000);
        check("ar_rel_req",  32'(imem_req),  32'h1);
        check("ar_rel_vld",  32'(if_valid),  32'h0);
        step;
        check("ar_rel_got_vld", 32'(if_valid), 32'h1);
        check("ar_rel_got_pc",  32'(if_pc),    32'h0000);
        check("ar_rel_instr",   32'(if_instr), 32'hE000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter RESET_PC, default 16'h0000: PC value loaded at reset.
REQ-002 Parameter PC_INC, default 16'd2: sequential PC increment (byte-addressed 16-bit instructions).
REQ-003 clk  in  1  single clock; all state on rising edge.
REQ-004 reset  in  1  asynchronous, active-low; 0 clears all state immediately.
REQ-005 imem_req  out  1  instruction-memory request, held until imem_ack.
REQ-006 imem_addr  out  16  request address, registered; bit 0 always 0.
REQ-007 imem_ack  in  1  memory accepts request and returns data in the same cycle.
REQ-008 imem_rdata  in  16  instruction word, valid when imem_ack=1.
REQ-009 redirect  in  1  jump/branch taken; one-cycle pulse from execute.
REQ-010 redirect_pc  in  16  target PC, sampled when redirect=1.
REQ-011 if_valid  out  1  fetched instruction presented to decode.
REQ-012 if_ready  in  1  decode accepts the instruction when if_valid=1.
REQ-013 if_instr  out  16  fetched instruction word.
REQ-014 if_opcode  out  3  if_instr[15:13], the control-unit opcode.
REQ-015 if_pc  out  16  address of if_instr.
REQ-016 if_pc_plus  out  16  if_pc+PC_INC modulo 2^16, the jal link value.

Function
REQ-017 States IDLE, FETCH, HOLD, DROP; encoding is free.
REQ-018 IDLE: imem_req=0, if_valid=0; go to FETCH on the first edge after reset release.
REQ-019 FETCH: imem_req=1, imem_addr=pc; hold both stable until imem_ack.
REQ-020 FETCH with imem_ack and no redirect: capture imem_rdata/pc into the output register; if_valid=1 next cycle; pc<=pc+PC_INC; go to HOLD.
REQ-021 HOLD: imem_req=0; output register stable while if_ready=0.
REQ-022 HOLD with if_ready=1: if_valid=0 next cycle; go to FETCH. Peak throughput is one instruction per 2 cycles.
REQ-023 Redirect has priority over imem_ack and over the decode handshake in every state.
REQ-024 Redirect in IDLE or HOLD: pc<=redirect_pc; if_valid=0 next cycle; the held instruction is discarded, not consumed; go to FETCH.
REQ-025 Redirect in FETCH with imem_ack the same cycle: discard imem_rdata; pc<=redirect_pc; remain in FETCH with a new address next cycle.
REQ-026 Redirect in FETCH without imem_ack: latch the target; go to DROP.
REQ-027 DROP: imem_req=1 with the old imem_addr unchanged; on imem_ack, discard data, pc<=latched target, go to FETCH.
REQ-028 Redirect in DROP: overwrite the latched target; stay in DROP.
REQ-029 redirect_pc bit 0 is forced to 0 when loaded.
REQ-030 PC arithmetic is 16-bit modulo: 16'hFFFE+2=16'h0000, with no flag or stall.
REQ-031 if_valid never asserts for data returned by a request that a redirect overtook.

Reset
REQ-032 While reset=0: state=IDLE, pc=RESET_PC, imem_req=0, imem_addr=0, if_valid=0, if_instr=0, if_opcode=0, if_pc=0, if_pc_plus=0, latched target=0.
REQ-033 Reset asserted mid-transaction abandons it; after release, fetch restarts at RESET_PC and any late imem_ack before the new request is ignored.

Verification
REQ-034 Release reset with imem_ack tied to 1, if_ready=1, rdata=16'h2004 -> addresses 0000,0002,0004 issued on alternate cycles; if_opcode=3'b001; if_pc_plus=if_pc+2.
REQ-035 if_ready=0 for 5 cycles in HOLD -> if_instr/if_pc stable, imem_req=0, no PC advance; release -> next fetch at if_pc+2.
REQ-036 imem_ack delayed 3 cycles, redirect to 16'h0041 in the 2nd cycle -> imem_addr is unchanged until ack, data is discarded, next request at 16'h0040, and no if_valid for the discarded word.
REQ-037 Redirect to 16'h0100 in the same cycle as imem_ack -> no if_valid; next imem_addr=16'h0100.
REQ-038 Redirect in HOLD with if_ready=1 the same cycle -> instruction is dropped (if_valid=0 next cycle); fetch resumes at the target.
REQ-039 PC at 16'hFFFE -> next sequential address is 16'h0000; asynchronous reset mid-DROP -> all outputs zero immediately, and the first request after release is at RESET_PC.
